ssfr_loader: RTL and testbench
==============================

# ssfr_loader

Byte-stream configuration master for the SSFR configuration register. It accepts framed bytes from the host link over a valid/ready handshake and assembles each write frame into a DA/DB pair. It then issues the single-cycle EN_CONFIG strobe that loads the 16-bit SSFR. Optionally, it returns the current SSFR value to the host over a transmit handshake.

## Interface
- TIMEOUT_CYCLES, 255: maximum idle cycles between bytes of a frame before the frame is aborted; legal range 1..65535.
- CLKEXT  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- RX_DATA  in  8  host byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader can accept a byte.
- DA  out  8  SSFR high byte, to the config register.
- DB  out  8  SSFR low byte, to the config register.
- EN_CONFIG  out  1  one-cycle write strobe, to the config register.
- SSFR  in  16  current register value, used for readback.
- TX_DATA  out  8  readback byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  host accepts the readback byte.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  sticky frame error flag.

## Operation
- A byte is accepted on a rising edge where RX_VALID and RX_READY are both high.
- Frame header byte 0xA5 starts a write frame: header, DA byte, DB byte.
- Frame header byte 0x5A starts a read frame (readback). It is legal only when readback is compiled in.
- Write path states and transitions:
  - IDLE: header 0xA5 goes to W_HI. Any other byte (including 0x5A without readback) sets ERR and stays in IDLE.
  - W_HI: the accepted byte is registered into DA; go to W_LO.
  - W_LO: the accepted byte is registered into DB; go to COMMIT.
  - COMMIT: EN_CONFIG=1 for this one state; go to IDLE.
- Read path states and transitions:
  - IDLE: header 0x5A samples SSFR into a 16-bit holding register, then goes to R_HI.
  - R_HI: TX_VALID=1, TX_DATA=hold[15:8]. Stay until TX_READY=1, then go to R_LO.
  - R_LO: TX_VALID=1, TX_DATA=hold[7:0]. Stay until TX_READY=1, then go to IDLE.
- RX_READY=1 only in IDLE, W_HI and W_LO. It is combinational from state only, never from RX_VALID.
- Timeout counter:
  - Counts cycles spent in W_HI or W_LO with no accepted byte; cleared on every accepted byte and on leaving those states.
  - When the counter equals TIMEOUT_CYCLES: go to IDLE, set ERR, issue no EN_CONFIG.
  - DA/DB keep whatever partial value was loaded.
- ERR is sticky. It clears on the edge that accepts a valid header (0xA5, or 0x5A with readback). If an error event and a clear occur on the same edge, the error wins.
- DA and DB hold their last values outside COMMIT. They only change on byte acceptance in W_HI/W_LO.
- The read path has no timeout; it waits for TX_READY indefinitely.

## Timing
- Reset values: state IDLE, DA=0x00, DB=0x00, EN_CONFIG=0, RX_READY=1, TX_VALID=0, TX_DATA=0x00, BUSY=0, ERR=0, counter=0, hold=0.
- Reset asserted mid-frame returns to IDLE immediately (asynchronous), and no EN_CONFIG is emitted.
- DB accepted at edge N:
  - EN_CONFIG is high from edge N to N+1, with DA/DB stable.
  - The config register captures at edge N+1.
  - The loader is back in IDLE after edge N+1 and can accept a new header at edge N+2.
- Minimum write frame: 4 cycles, header to strobe deassertion.
- TX_DATA/TX_VALID are registered, or decoded from registered state only. TX_DATA is stable while TX_VALID=1 and TX_READY=0.
- Read frame with TX_READY tied high: the header accepted at edge N gives byte 0 in cycle N..N+1 and byte 1 in cycle N+1..N+2. The loader is back in IDLE after edge N+2.
- Timeout: the last accepted byte at edge N gives the IDLE transition, with ERR high, at edge N+TIMEOUT_CYCLES.

## Configuration
- SSFR_READBACK_EN defined: read path, holding register and TX handshake are implemented as described above.
- SSFR_READBACK_EN undefined:
  - No R_HI/R_LO states and no holding register.
  - TX_VALID=0 and TX_DATA=0x00 constant; TX_READY and SSFR are ignored.
  - Header 0x5A is an unknown byte and sets ERR.
  - Ports are unchanged in both builds.

## Test plan
- Reset, then bytes 0xA5,0x12,0x34 back-to-back with RX_VALID held high -> DA=0x12, DB=0x34. EN_CONFIG is high for exactly one cycle, the cycle after 0x34 is accepted; a connected SSFR reads 0x1234. BUSY is low afterwards.
- Byte 0x00 in IDLE -> ERR=1, no EN_CONFIG. A following 0xA5,0xFF,0x00 frame -> ERR clears on the header edge, and SSFR=0xFF00.
- TIMEOUT_CYCLES=8: send 0xA5,0x77, then idle 8 cycles -> IDLE with ERR=1 at the 8th cycle, no EN_CONFIG, DA=0x77, DB unchanged.
- Readback build, SSFR=0x2280, TX_READY low 3 cycles then high -> TX_DATA=0x22 held stable while stalled, then 0x80. RX_READY=0 throughout, and the loader is in IDLE afterwards.
- Non-readback build: byte 0x5A -> ERR=1, TX_VALID stays 0.
- Assert RST one cycle after the DA byte is accepted -> all outputs return to reset values, no EN_CONFIG. A subsequent full frame works normally.

Source files
------------

// File: rtl/ssfr_loader.sv
// ssfr_loader: byte-stream configuration master for the 16-bit SSFR register.
// Write frame 0xA5,DA,DB gives a one-cycle EN_CONFIG strobe. Read frame 0x5A returns
// SSFR as two bytes over the TX handshake when SSFR_READBACK_EN is defined.
// Ports:
//   CLKEXT, RST            clock, async active-high reset
//   RX_DATA/VALID/READY    host byte input handshake (READY decoded from state only)
//   DA, DB, EN_CONFIG      config register data bytes and one-cycle load strobe
//   SSFR                   current register value, sampled for readback
//   TX_DATA/VALID/READY    readback byte output handshake
//   BUSY, ERR              not-idle indicator, sticky frame error flag
// Optional feature macro: SSFR_READBACK_EN (read path, holding register, TX handshake).
// Without the macro TX_VALID/TX_DATA are tied low, and 0x5A is treated as an unknown header.

module ssfr_loader #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLKEXT,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [7:0]  DA,
  output logic [7:0]  DB,
  output logic        EN_CONFIG,
  input  logic [15:0] SSFR,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [7:0]  HDR_WR  = 8'hA5;
  localparam logic [7:0]  HDR_RD  = 8'h5A;
  // The counter value reached on the idle edge that precedes the timeout edge.
  // Firing when it is already TIMEOUT_CYCLES-1 puts the abort exactly
  // TIMEOUT_CYCLES edges after the last accepted byte.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

`ifdef SSFR_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_HI   = 3'd1,
    S_W_LO   = 3'd2,
    S_COMMIT = 3'd3,
    S_R_HI   = 3'd4,
    S_R_LO   = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_W_HI   = 2'd1,
    S_W_LO   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;
`endif

  state_t      state;
  logic [15:0] idle_cnt;
  logic [7:0]  da_q;
  logic [7:0]  db_q;
  logic        en_q;
  logic        err_q;
  logic        rx_rdy;
  logic        accept;

  // Ready depends on state alone, so the host never sees a path from its
  // own valid back to ready.
  assign rx_rdy   = (state == S_IDLE) || (state == S_W_HI) || (state == S_W_LO);
  assign accept   = RX_VALID && rx_rdy;

  assign RX_READY  = rx_rdy;
  assign DA        = da_q;
  assign DB        = db_q;
  assign EN_CONFIG = en_q;
  assign BUSY      = (state != S_IDLE);
  assign ERR       = err_q;

`ifdef SSFR_READBACK_EN
  logic [15:0] hold;

  // TX outputs are decoded from registered state and the holding register,
  // so TX_DATA cannot move while a byte is stalled.
  always_comb begin
    TX_VALID = 1'b0;
    TX_DATA  = 8'h00;
    if (state == S_R_HI) begin
      TX_VALID = 1'b1;
      TX_DATA  = hold[15:8];
    end else if (state == S_R_LO) begin
      TX_VALID = 1'b1;
      TX_DATA  = hold[7:0];
    end
  end
`else
  assign TX_VALID = 1'b0;
  assign TX_DATA  = 8'h00;

  // Readback inputs are deliberately ignored in this build.
  logic unused_rb;
  assign unused_rb = &{1'b0, TX_READY, SSFR};
`endif

  always_ff @(posedge CLKEXT or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      idle_cnt <= 16'd0;
      da_q     <= 8'h00;
      db_q     <= 8'h00;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef SSFR_READBACK_EN
      hold     <= 16'h0000;
`endif
    end else begin
      // Strobe is high only for the single cycle spent in COMMIT.
      en_q <= 1'b0;

      case (state)
        S_IDLE: begin
          idle_cnt <= 16'd0;
          if (accept) begin
            if (RX_DATA == HDR_WR) begin
              state <= S_W_HI;
              err_q <= 1'b0;
`ifdef SSFR_READBACK_EN
            end else if (RX_DATA == HDR_RD) begin
              hold  <= SSFR;
              state <= S_R_HI;
              err_q <= 1'b0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_W_HI: begin
          if (accept) begin
            da_q     <= RX_DATA;
            idle_cnt <= 16'd0;
            state    <= S_W_LO;
          end else if (idle_cnt == TO_LAST) begin
            idle_cnt <= 16'd0;
            err_q    <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end

        S_W_LO: begin
          if (accept) begin
            db_q     <= RX_DATA;
            idle_cnt <= 16'd0;
            en_q     <= 1'b1;
            state    <= S_COMMIT;
          end else if (idle_cnt == TO_LAST) begin
            // Partial DA stays loaded; only the strobe is withheld.
            idle_cnt <= 16'd0;
            err_q    <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end

        S_COMMIT: begin
          idle_cnt <= 16'd0;
          state    <= S_IDLE;
        end

`ifdef SSFR_READBACK_EN
        // Read path waits on the host indefinitely; no timeout here.
        S_R_HI: begin
          idle_cnt <= 16'd0;
          if (TX_READY) state <= S_R_LO;
        end

        S_R_LO: begin
          idle_cnt <= 16'd0;
          if (TX_READY) state <= S_IDLE;
        end
`endif

        default: begin
          idle_cnt <= 16'd0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssfr_loader.sv
// tb_ssfr_loader: directed test of ssfr_loader with a small model of the
// external config register (captures {DA,DB} on EN_CONFIG) feeding SSFR.
// Inputs are driven 1ns after the rising edge; outputs are sampled there too.

module tb_ssfr_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  da;
  logic [7:0]  db;
  logic        en_config;
  logic [15:0] ssfr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int en_base;

  ssfr_loader #(.TIMEOUT_CYCLES(8)) dut (
    .CLKEXT    (clk),
    .RST       (rst),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .RX_READY  (rx_ready),
    .DA        (da),
    .DB        (db),
    .EN_CONFIG (en_config),
    .SSFR      (ssfr),
    .TX_DATA   (tx_data),
    .TX_VALID  (tx_valid),
    .TX_READY  (tx_ready),
    .BUSY      (busy),
    .ERR       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SSFR register model and strobe counter.
  initial ssfr = 16'h0000;
  always @(posedge clk) begin
    if (en_config) begin
      ssfr   <= {da, db};
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns 1ns after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!rx_ready) check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    #2;
    // Reset state
    check_eq("rst_da",       32'(da),        32'h00);
    check_eq("rst_db",       32'(db),        32'h00);
    check_eq("rst_en",       32'(en_config), 32'd0);
    check_eq("rst_rx_ready", 32'(rx_ready),  32'd1);
    check_eq("rst_tx_valid", 32'(tx_valid),  32'd0);
    check_eq("rst_tx_data",  32'(tx_data),   32'h00);
    check_eq("rst_busy",     32'(busy),      32'd0);
    check_eq("rst_err",      32'(err),       32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Back-to-back write frame A5,12,34 (valid held high across bytes)
    send_byte(8'hA5);
    send_byte(8'h12);
    rx_data  = 8'h34;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_eq("w1_en_high", 32'(en_config), 32'd1);
    check_eq("w1_da",      32'(da),        32'h12);
    check_eq("w1_db",      32'(db),        32'h34);
    check_eq("w1_busy",    32'(busy),      32'd1);
    check_eq("w1_rdy_commit", 32'(rx_ready), 32'd0);
    tick();
    check_eq("w1_en_low",  32'(en_config), 32'd0);
    check_eq("w1_busy_lo", 32'(busy),      32'd0);
    check_eq("w1_ssfr",    32'(ssfr),      32'h1234);
    check_eq("w1_en_cnt",  32'(en_cnt),    32'd1);

    // Timeout: A5,77 then idle 8 cycles
    en_base = en_cnt;
    send_byte(8'hA5);
    send_byte(8'h77);
    for (int i = 0; i < 7; i++) tick();
    check_eq("to_busy_7",  32'(busy), 32'd1);
    check_eq("to_err_7",   32'(err),  32'd0);
    tick();
    check_eq("to_busy_8",  32'(busy), 32'd0);
    check_eq("to_err_8",   32'(err),  32'd1);
    check_eq("to_da",      32'(da),   32'h77);
    check_eq("to_db",      32'(db),   32'h34);
    tick();
    check_eq("to_no_en",   32'(en_cnt - en_base), 32'd0);
    check_eq("to_ssfr",    32'(ssfr), 32'h1234);

    // Unknown byte then a clean frame clears ERR on the header edge
    send_byte(8'hA5);
    check_eq("clr_err_hdr", 32'(err), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    check_eq("to2_err",    32'(err), 32'd1);
    en_base = en_cnt;
    send_byte(8'h00);
    check_eq("bad_err",    32'(err),  32'd1);
    check_eq("bad_busy",   32'(busy), 32'd0);
    send_byte(8'hA5);
    check_eq("hdr_clr",    32'(err),  32'd0);
    send_byte(8'hFF);
    send_byte(8'h00);
    tick();
    check_eq("w2_ssfr",    32'(ssfr), 32'hFF00);
    check_eq("w2_en_cnt",  32'(en_cnt - en_base), 32'd1);

`ifdef SSFR_READBACK_EN
    // Readback with TX_READY stalled for three cycles
    send_byte(8'hA5);
    send_byte(8'h22);
    send_byte(8'h80);
    tick();
    check_eq("rb_ssfr",    32'(ssfr), 32'h2280);
    tx_ready = 1'b0;
    send_byte(8'h5A);
    for (int i = 0; i < 3; i++) begin
      check_eq("rb_hi_valid", 32'(tx_valid), 32'd1);
      check_eq("rb_hi_data",  32'(tx_data),  32'h22);
      check_eq("rb_hi_rdy",   32'(rx_ready), 32'd0);
      if (i < 2) tick();
    end
    tx_ready = 1'b1;
    tick();
    check_eq("rb_lo_valid", 32'(tx_valid), 32'd1);
    check_eq("rb_lo_data",  32'(tx_data),  32'h80);
    check_eq("rb_lo_rdy",   32'(rx_ready), 32'd0);
    tick();
    tx_ready = 1'b0;
    check_eq("rb_done_valid", 32'(tx_valid), 32'd0);
    check_eq("rb_done_busy",  32'(busy),     32'd0);
    check_eq("rb_done_rdy",   32'(rx_ready), 32'd1);
    check_eq("rb_err",        32'(err),      32'd0);
`else
    // 0x5A is an unknown header without readback
    tx_ready = 1'b1;
    send_byte(8'h5A);
    check_eq("nrb_err",      32'(err),      32'd1);
    check_eq("nrb_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("nrb_busy",     32'(busy),     32'd0);
    tick();
    check_eq("nrb_tx_valid2", 32'(tx_valid), 32'd0);
    check_eq("nrb_tx_data",   32'(tx_data),  32'h00);
    tx_ready = 1'b0;
`endif

    // Reset mid-frame, one cycle after DA is accepted
    en_base = en_cnt;
    send_byte(8'hA5);
    send_byte(8'h99);
    tick();
    rst = 1'b1;
    #1;
    check_eq("mrst_da",    32'(da),        32'h00);
    check_eq("mrst_db",    32'(db),        32'h00);
    check_eq("mrst_en",    32'(en_config), 32'd0);
    check_eq("mrst_busy",  32'(busy),      32'd0);
    check_eq("mrst_rdy",   32'(rx_ready),  32'd1);
    check_eq("mrst_err",   32'(err),       32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("mrst_no_en", 32'(en_cnt - en_base), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h5C);
    send_byte(8'h3E);
    tick();
    check_eq("post_ssfr",   32'(ssfr), 32'h5C3E);
    check_eq("post_en_cnt", 32'(en_cnt - en_base), 32'd1);
    check_eq("post_busy",   32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
